dripper_valve_actuator: RTL and testbench

Responder side of the dripper valve command. Receives the level command `dripper_valvule` from the irrigation controller and drives the valve motor in the open or close direction. It confirms each travel with the limit-switch feedback, enforces a minimum dwell time against chatter, and latches a fault on timeout or on contradictory feedback. It sits between the irrigation controller and the physical drip valve. Its status outputs feed back to the controller.

---
 rtl/dripper_valve_actuator.sv | 135 +++++++++++++
 tb/tb_dripper_valve_actuator.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dripper_valve_actuator.sv
`default_nettype none
// ============================================================================
//  Module      : dripper_valve_actuator
//  Description : Responder side of the dripper valve command. Follows the
//                level command from the irrigation controller. Drives the
//                valve motor open or closed and confirms each travel on the
//                limit switches. A minimum dwell time between moves stops
//                chatter. A fault is latched on a travel timeout or on
//                contradictory limit feedback.
//
//  Ports       : clk             - system clock, rising edge
//                reset           - synchronous, active-high reset
//                dripper_valvule - command level (1 = open, 0 = closed)
//                open_limit      - fully-open limit switch
//                closed_limit    - fully-closed limit switch
//                fault_clear     - level; leaves FAULT when high
//                motor_open      - drive motor in the open direction
//                motor_close     - drive motor in the close direction
//                valve_is_open   - valve confirmed open
//                busy            - travel in progress
//                fault           - actuator fault latched
//
//  Revision    : 1.0 - initial release
// ============================================================================
module dripper_valve_actuator #(
    parameter int MIN_HOLD       = 4,
    parameter int TRAVEL_TIMEOUT = 16,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic dripper_valvule,
    input  logic open_limit,
    input  logic closed_limit,
    input  logic fault_clear,
    output logic motor_open,
    output logic motor_close,
    output logic valve_is_open,
    output logic busy,
    output logic fault
);

    localparam logic [2:0] S_CLOSED  = 3'd0;
    localparam logic [2:0] S_OPENING = 3'd1;
    localparam logic [2:0] S_OPEN    = 3'd2;
    localparam logic [2:0] S_CLOSING = 3'd3;
    localparam logic [2:0] S_FAULT   = 3'd4;

    // The counter holds the number of cycles already spent in the current
    // state. The dwell test therefore compares against MIN_HOLD-1, and the
    // timeout fires on the last allowed travel cycle.
    localparam logic [CNT_W-1:0] c_HOLD_LAST   = CNT_W'(MIN_HOLD - 1);
    localparam logic [CNT_W-1:0] c_TRAVEL_LAST = CNT_W'(TRAVEL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [CNT_W-1:0] r_cnt;

    // State register and shared dwell/travel counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_CLOSING;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        // Both limits active at once is physically impossible. It outranks
        // every other transition. FAULT itself ignores the limits.
        if ((r_state != S_FAULT) && open_limit && closed_limit) begin
            w_next_state = S_FAULT;
        end else begin
            case (r_state)
                S_CLOSED: begin
                    if (!closed_limit) begin
                        w_next_state = S_FAULT;
                    end else if (dripper_valvule && (r_cnt >= c_HOLD_LAST)) begin
                        w_next_state = S_OPENING;
                    end
                end
                S_OPENING: begin
                    // A limit arriving on the timeout cycle still wins.
                    if (open_limit) begin
                        w_next_state = S_OPEN;
                    end else if (r_cnt == c_TRAVEL_LAST) begin
                        w_next_state = S_FAULT;
                    end
                end
                S_OPEN: begin
                    if (!open_limit) begin
                        w_next_state = S_FAULT;
                    end else if (!dripper_valvule && (r_cnt >= c_HOLD_LAST)) begin
                        w_next_state = S_CLOSING;
                    end
                end
                S_CLOSING: begin
                    if (closed_limit) begin
                        w_next_state = S_CLOSED;
                    end else if (r_cnt == c_TRAVEL_LAST) begin
                        w_next_state = S_FAULT;
                    end
                end
                S_FAULT: begin
                    if (fault_clear) begin
                        w_next_state = S_CLOSING;
                    end
                end
                default: begin
                    // An unused encoding is treated as a fault. The operator
                    // must clear it, and the valve is then driven shut.
                    w_next_state = S_FAULT;
                end
            endcase
        end
    end

    // Moore outputs decode the registered state only.
    assign motor_open    = (r_state == S_OPENING);
    assign motor_close   = (r_state == S_CLOSING);
    assign valve_is_open = (r_state == S_OPEN);
    assign busy          = (r_state == S_OPENING) || (r_state == S_CLOSING);
    assign fault         = (r_state == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_dripper_valve_actuator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dripper_valve_actuator
//  Description : Self-checking bench for dripper_valve_actuator. It runs a
//                directed vector table, then hand-written corner-case
//                sequences, then random stimulus checked against a
//                behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dripper_valve_actuator;

    localparam int MIN_HOLD       = 4;
    localparam int TRAVEL_TIMEOUT = 16;
    localparam int CNT_W          = 8;
    localparam int RAND_CYCLES    = 3000;

    // Expected output vectors, ordered {motor_open, motor_close, valve_is_open, busy, fault}
    localparam logic [4:0] E_CLOSED  = 5'b00000;
    localparam logic [4:0] E_OPENING = 5'b10010;
    localparam logic [4:0] E_OPEN    = 5'b00100;
    localparam logic [4:0] E_CLOSING = 5'b01010;
    localparam logic [4:0] E_FAULT   = 5'b00001;

    logic clk = 1'b0;
    logic reset, dripper_valvule, open_limit, closed_limit, fault_clear;
    logic motor_open, motor_close, valve_is_open, busy, fault;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_no   = 0;

    dripper_valve_actuator #(
        .MIN_HOLD(MIN_HOLD),
        .TRAVEL_TIMEOUT(TRAVEL_TIMEOUT),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .dripper_valvule(dripper_valvule),
        .open_limit(open_limit),
        .closed_limit(closed_limit),
        .fault_clear(fault_clear),
        .motor_open(motor_open),
        .motor_close(motor_close),
        .valve_is_open(valve_is_open),
        .busy(busy),
        .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       cmd;
        logic       ol;
        logic       cl;
        logic       fc;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic c, input logic o,
                                input logic l, input logic f, input logic [4:0] e);
        vec_t v;
        v.rst = r; v.cmd = c; v.ol = o; v.cl = l; v.fc = f; v.exp = e;
        return v;
    endfunction

    // Applies one cycle of inputs, waits for the edge, then checks the outputs 1 ns later.
    task automatic cyc(input logic r, input logic c, input logic o, input logic l,
                       input logic f, input logic [4:0] e, input string name);
        logic [4:0] got;
        reset = r; dripper_valvule = c; open_limit = o; closed_limit = l; fault_clear = f;
        @(posedge clk);
        #1;
        cyc_no++;
        got = {motor_open, motor_close, valve_is_open, busy, fault};
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got mo/mc/vo/busy/fault=%b expected=%b", name, cyc_no, got, e);
        end
    endtask

    // Reset, settle in CLOSED, then wait out the hold time so the next edge enters OPENING.
    task automatic go_opening(input string name);
        cyc(1, 0, 0, 1, 0, E_CLOSING, name);
        cyc(0, 1, 0, 1, 0, E_CLOSED, name);
        for (int i = 0; i < MIN_HOLD - 1; i++) cyc(0, 1, 0, 1, 0, E_CLOSED, name);
        cyc(0, 1, 0, 1, 0, E_OPENING, name);
    endtask

    // ---------------- behavioural reference model ----------------
    typedef enum {M_CLOSED, M_OPENING, M_OPEN, M_CLOSING, M_FAULT} mstate_t;
    mstate_t m_st = M_CLOSING;
    int      m_t  = 0;   // cycles already spent in m_st

    function automatic void model_step(input logic r, input logic c, input logic o,
                                       input logic l, input logic f);
        mstate_t n;
        if (r) begin
            m_st = M_CLOSING; m_t = 0;
            return;
        end
        n = m_st;
        if (m_st != M_FAULT && o && l) n = M_FAULT;
        else begin
            case (m_st)
                M_CLOSED:  n = !l ? M_FAULT : ((c && m_t + 1 >= MIN_HOLD) ? M_OPENING : M_CLOSED);
                M_OPENING: n = o ? M_OPEN : ((m_t + 1 == TRAVEL_TIMEOUT) ? M_FAULT : M_OPENING);
                M_OPEN:    n = !o ? M_FAULT : ((!c && m_t + 1 >= MIN_HOLD) ? M_CLOSING : M_OPEN);
                M_CLOSING: n = l ? M_CLOSED : ((m_t + 1 == TRAVEL_TIMEOUT) ? M_FAULT : M_CLOSING);
                default:   n = f ? M_CLOSING : M_FAULT;
            endcase
        end
        m_t  = (n != m_st) ? 0 : m_t + 1;
        m_st = n;
    endfunction

    function automatic logic [4:0] model_out();
        case (m_st)
            M_CLOSED:  return E_CLOSED;
            M_OPENING: return E_OPENING;
            M_OPEN:    return E_OPEN;
            M_CLOSING: return E_CLOSING;
            default:   return E_FAULT;
        endcase
    endfunction

    function automatic logic pct(input int p);
        return ($urandom_range(99) < p);
    endfunction

    initial begin
        logic r, c, o, l, f;
        logic [4:0] got;

        reset = 1'b1; dripper_valvule = 1'b0; open_limit = 1'b0;
        closed_limit = 1'b0; fault_clear = 1'b0;

        // ---------------- directed table ----------------
        // Reset with closed_limit low, then the limit rises three cycles after release.
        tbl.push_back(mk(1, 0, 0, 0, 0, E_CLOSING));
        tbl.push_back(mk(1, 0, 0, 0, 0, E_CLOSING));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 0, 0, E_CLOSING));
        tbl.push_back(mk(0, 1, 0, 1, 0, E_CLOSED));
        // The open command waits out the hold: motor_open on the 4th edge after CLOSED.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 0, 1, 0, E_CLOSED));
        tbl.push_back(mk(0, 1, 0, 1, 0, E_OPENING));
        // open_limit arrives on the 5th OPENING cycle.
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 0, 0, 0, E_OPENING));
        tbl.push_back(mk(0, 1, 1, 0, 0, E_OPEN));
        // The command drops on the first OPEN cycle. Closing starts only after 4 cycles in OPEN.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 1, 0, 0, E_OPEN));
        tbl.push_back(mk(0, 0, 1, 0, 0, E_CLOSING));
        // closed_limit arrives on the 16th CLOSING cycle (timeout boundary), so the limit wins.
        for (int i = 0; i < 15; i++) tbl.push_back(mk(0, 0, 0, 0, 0, E_CLOSING));
        tbl.push_back(mk(0, 1, 0, 1, 0, E_CLOSED));
        // Open again, then let OPENING time out: 16 cycles of motor_open, then FAULT.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 0, 1, 0, E_CLOSED));
        tbl.push_back(mk(0, 1, 0, 1, 0, E_OPENING));
        for (int i = 0; i < 15; i++) tbl.push_back(mk(0, 1, 0, 0, 0, E_OPENING));
        tbl.push_back(mk(0, 1, 0, 0, 0, E_FAULT));
        // FAULT ignores the limits, and fault_clear goes to CLOSING.
        tbl.push_back(mk(0, 1, 1, 1, 0, E_FAULT));
        tbl.push_back(mk(0, 0, 0, 0, 1, E_CLOSING));
        tbl.push_back(mk(0, 0, 0, 1, 0, E_CLOSED));

        foreach (tbl[i]) cyc(tbl[i].rst, tbl[i].cmd, tbl[i].ol, tbl[i].cl, tbl[i].fc, tbl[i].exp, "table");

        // ---------------- hand-written corner cases ----------------
        // Both limits at once while OPEN.
        go_opening("contra");
        cyc(0, 1, 1, 0, 0, E_OPEN, "contra");
        cyc(0, 1, 1, 1, 0, E_FAULT, "contra_both_limits");
        // open_limit drops while OPEN. Then reset in FAULT while fault_clear is high.
        go_opening("drift_open");
        cyc(0, 1, 1, 0, 0, E_OPEN, "drift_open");
        cyc(0, 1, 0, 0, 0, E_FAULT, "drift_open_fault");
        cyc(1, 0, 0, 0, 1, E_CLOSING, "reset_in_fault");
        // closed_limit drops while CLOSED.
        cyc(0, 0, 0, 1, 0, E_CLOSED, "drift_closed");
        cyc(0, 0, 0, 0, 0, E_FAULT, "drift_closed_fault");
        // Toggling the command during OPENING does not reverse the travel.
        go_opening("no_reversal");
        for (int i = 0; i < 6; i++) cyc(0, logic'(i[0]), 0, 0, 0, E_OPENING, "no_reversal");
        cyc(0, 0, 1, 0, 0, E_OPEN, "no_reversal_open");
        // Reset mid-OPENING.
        go_opening("reset_mid");
        cyc(0, 1, 0, 0, 0, E_OPENING, "reset_mid");
        cyc(1, 1, 0, 0, 0, E_CLOSING, "reset_mid_opening");
        // A command pulse shorter than the hold time is lost.
        cyc(0, 0, 0, 1, 0, E_CLOSED, "short_pulse");
        cyc(0, 1, 0, 1, 0, E_CLOSED, "short_pulse");
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, E_CLOSED, "short_pulse_lost");

        // ---------------- randomized against the model ----------------
        cyc(1, 0, 0, 0, 0, E_CLOSING, "rand_reset");
        m_st = M_CLOSING; m_t = 0;
        c = 1'b0;
        for (int k = 0; k < RAND_CYCLES; k++) begin
            r = pct(1);
            if (pct(10)) c = ~c;
            f = pct(15);
            case (m_st)
                M_OPENING: begin o = pct(12); l = pct(2); end
                M_CLOSING: begin o = pct(2);  l = pct(12); end
                M_OPEN:    begin o = pct(97); l = pct(2); end
                M_CLOSED:  begin o = pct(2);  l = pct(97); end
                default:   begin o = pct(50); l = pct(50); end
            endcase
            reset = r; dripper_valvule = c; open_limit = o; closed_limit = l; fault_clear = f;
            @(posedge clk);
            model_step(r, c, o, l, f);
            #1;
            cyc_no++;
            got = {motor_open, motor_close, valve_is_open, busy, fault};
            n_checks++;
            if (got !== model_out()) begin
                n_fail++;
                $display("FAIL random cycle=%0d got mo/mc/vo/busy/fault=%b expected=%b",
                         cyc_no, got, model_out());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
